// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester handshakes, result return and shared-ALU drive
// signals for alu_share_arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
);
  logic             req0;
  logic [OPW-1:0]   op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [OPW-1:0]   op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_out;

  // Arbiter side
  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    output done0, done1, result, busy, alu_op, alu_in1, alu_in2
  );

  // Requester / ALU side
  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1, alu_out,
    input  done0, done1, result, busy, alu_op, alu_in1, alu_in2
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The winner's operands are held on the ALU for EXEC_CYCLES cycles, the ALU
// output is captured into result, and a one-cycle done pulse goes back to
// the winner.
module alu_share_arbiter #(
  parameter int WIDTH       = 8,
  parameter int OPW         = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic             last_gnt;
  logic             gnt;
  logic [CW-1:0]    cnt;
  logic             done0_q;
  logic             done1_q;
  logic             busy_q;
  logic [WIDTH-1:0] result_q;
  logic [OPW-1:0]   alu_op_q;
  logic [WIDTH-1:0] alu_in1_q;
  logic [WIDTH-1:0] alu_in2_q;
  logic             pick1;

  // Port 1 wins when it alone requests, or on a tie when port 0 was served last.
  always_comb begin
    pick1 = bus.req1 && (!bus.req0 || !last_gnt);
  end

  // Arbitration FSM; the ALU drive registers double as the operand latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      cnt       <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
      result_q  <= '0;
      alu_op_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt       <= pick1;
            last_gnt  <= pick1;
            alu_op_q  <= pick1 ? bus.op1 : bus.op0;
            alu_in1_q <= pick1 ? bus.a1  : bus.a0;
            alu_in2_q <= pick1 ? bus.b1  : bus.b0;
            cnt       <= CNT_LOAD;
            busy_q    <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            result_q <= bus.alu_out;
            done0_q  <= !gnt;
            done1_q  <= gnt;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done0_q   <= 1'b0;
          done1_q   <= 1'b0;
          busy_q    <= 1'b0;
          alu_op_q  <= '0;
          alu_in1_q <= '0;
          alu_in2_q <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.busy    = busy_q;
  assign bus.result  = result_q;
  assign bus.alu_op  = alu_op_q;
  assign bus.alu_in1 = alu_in1_q;
  assign bus.alu_in2 = alu_in2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter: one instance with
// EXEC_CYCLES=1 and one with EXEC_CYCLES=4, each feeding a bench-side ALU.
module tb_alu_share_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_share_arbiter_if #(.WIDTH(8), .OPW(3)) b1 ();
  alu_share_arbiter_if #(.WIDTH(8), .OPW(3)) b4 ();

  alu_share_arbiter #(.WIDTH(8), .OPW(3), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  alu_share_arbiter #(.WIDTH(8), .OPW(3), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  // Shared ALU: 0 XOR, 1 AND, 2 OR, 3 ADD
  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0:    alu = x ^ y;
      3'd1:    alu = x & y;
      3'd2:    alu = x | y;
      3'd3:    alu = x + y;
      default: alu = '0;
    endcase
  endfunction

  assign b1.alu_out = alu(b1.alu_op, b1.alu_in1, b1.alu_in2);
  assign b4.alu_out = alu(b4.alu_op, b4.alu_in1, b4.alu_in2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    #1;
    vectors++;
    if ({b1.done0, b1.done1, b1.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags1: got %b want 000", {b1.done0, b1.done1, b1.busy});
    end
    vectors++;
    if ({b1.result, b1.alu_op, b1.alu_in1, b1.alu_in2} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_data1: got %h want 0", {b1.result, b1.alu_op, b1.alu_in1, b1.alu_in2});
    end
    vectors++;
    if ({b4.done0, b4.done1, b4.busy, b4.result, b4.alu_in1, b4.alu_in2} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_all4: got %h want 0", {b4.done0, b4.done1, b4.busy, b4.result, b4.alu_in1, b4.alu_in2});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_xor;
    logic exp_d0;
    @(negedge clk);
    b1.op0 = 3'd0; b1.a0 = 8'hA5; b1.b0 = 8'h3C; b1.req0 = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_d0 = (k == 2);
      vectors++;
      if (b1.done0 !== exp_d0) begin
        miscompares++;
        $display("FAIL single_done0 k=%0d: got %b want %b", k, b1.done0, exp_d0);
      end
      vectors++;
      if (b1.done1 !== 1'b0) begin
        miscompares++;
        $display("FAIL single_done1 k=%0d: got %b want 0", k, b1.done1);
      end
      if (k == 1) begin
        vectors++;
        if ({b1.busy, b1.alu_op, b1.alu_in1, b1.alu_in2} !== {1'b1, 3'd0, 8'hA5, 8'h3C}) begin
          miscompares++;
          $display("FAIL single_exec_drive: got %h want %h", {b1.busy, b1.alu_op, b1.alu_in1, b1.alu_in2}, {1'b1, 3'd0, 8'hA5, 8'h3C});
        end
        b1.a0 = 8'hEE; b1.b0 = 8'h11;
      end
      if (k == 2) begin
        vectors++;
        if (b1.result !== 8'h99) begin
          miscompares++;
          $display("FAIL single_result: got %h want 99", b1.result);
        end
        b1.req0 = 1'b0;
      end
      if (k == 3) begin
        vectors++;
        if ({b1.busy, b1.alu_in1, b1.alu_in2} !== 17'd0) begin
          miscompares++;
          $display("FAIL single_idle: got %h want 0", {b1.busy, b1.alu_in1, b1.alu_in2});
        end
      end
    end
  endtask

  task automatic test_tie_alternate;
    logic       exp_d0, exp_d1, exp_busy;
    logic [7:0] exp_res;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b1.op0 = 3'd0; b1.a0 = 8'hFF; b1.b0 = 8'h0F; b1.req0 = 1'b1;
    b1.op1 = 3'd0; b1.a1 = 8'h55; b1.b1 = 8'h55; b1.req1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_d0   = (k == 2) || (k == 8);
      exp_d1   = (k == 5) || (k == 11);
      exp_busy = (k % 3) != 0;
      exp_res  = (k < 2) ? 8'h00 : (k < 5) ? 8'hF0 : (k < 8) ? 8'h00 : (k < 11) ? 8'hF0 : 8'h00;
      vectors++;
      if ({b1.done0, b1.done1, b1.busy} !== {exp_d0, exp_d1, exp_busy}) begin
        miscompares++;
        $display("FAIL tie_flags k=%0d: got d0d1busy=%b want %b", k, {b1.done0, b1.done1, b1.busy}, {exp_d0, exp_d1, exp_busy});
      end
      if (k == 2 || k == 5 || k == 8 || k == 11 || k == 12) begin
        vectors++;
        if (b1.result !== exp_res) begin
          miscompares++;
          $display("FAIL tie_result k=%0d: got %h want %h", k, b1.result, exp_res);
        end
      end
      if (k == 11) begin
        b1.req0 = 1'b0; b1.req1 = 1'b0;
      end
    end
  endtask

  task automatic test_exec4;
    logic exp_d1;
    @(negedge clk);
    b4.op1 = 3'd0; b4.a1 = 8'h12; b4.b1 = 8'h34; b4.req1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_d1 = (k == 5);
      vectors++;
      if ({b4.done0, b4.done1} !== {1'b0, exp_d1}) begin
        miscompares++;
        $display("FAIL exec4_done k=%0d: got %b want %b", k, {b4.done0, b4.done1}, {1'b0, exp_d1});
      end
      if (k <= 4) begin
        vectors++;
        if ({b4.busy, b4.alu_in1, b4.alu_in2} !== {1'b1, 8'h12, 8'h34}) begin
          miscompares++;
          $display("FAIL exec4_hold k=%0d: got %h want %h", k, {b4.busy, b4.alu_in1, b4.alu_in2}, {1'b1, 8'h12, 8'h34});
        end
        b4.a1 = 8'hC0 + 8'(k); b4.b1 = 8'h0C;
      end
      if (k == 5) begin
        vectors++;
        if (b4.result !== 8'h26) begin
          miscompares++;
          $display("FAIL exec4_result: got %h want 26", b4.result);
        end
        b4.req1 = 1'b0;
      end
      if (k == 6) begin
        vectors++;
        if (b4.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL exec4_idle_busy: got %b want 0", b4.busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_exec;
    @(negedge clk);
    b1.op0 = 3'd3; b1.a0 = 8'h10; b1.b0 = 8'h20; b1.req0 = 1'b1;
    @(negedge clk);
    vectors++;
    if (b1.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy_before: got %b want 1", b1.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({b1.done0, b1.done1, b1.busy, b1.result, b1.alu_op, b1.alu_in1, b1.alu_in2} !== 30'd0) begin
      miscompares++;
      $display("FAIL rstmid_async_clear: got %h want 0", {b1.done0, b1.done1, b1.busy, b1.result, b1.alu_op, b1.alu_in1, b1.alu_in2});
    end
    @(negedge clk);
    vectors++;
    if (b1.done0 !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_no_done: got %b want 0", b1.done0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({b1.busy, b1.alu_in1, b1.alu_in2} !== {1'b1, 8'h10, 8'h20}) begin
      miscompares++;
      $display("FAIL rstmid_regrant: got %h want %h", {b1.busy, b1.alu_in1, b1.alu_in2}, {1'b1, 8'h10, 8'h20});
    end
    @(negedge clk);
    vectors++;
    if ({b1.done0, b1.result} !== {1'b1, 8'h30}) begin
      miscompares++;
      $display("FAIL rstmid_complete: got done0,result=%h want %h", {b1.done0, b1.result}, {1'b1, 8'h30});
    end
    b1.req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_drop_mid_exec;
    int pulses;
    pulses = 0;
    @(negedge clk);
    b1.op0 = 3'd1; b1.a0 = 8'hF3; b1.b0 = 8'h3E; b1.req0 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (b1.done0 === 1'b1) pulses++;
      if (k == 1) begin
        b1.req0 = 1'b0; b1.a0 = 8'h00; b1.b0 = 8'h00;
      end
      if (k == 2) begin
        vectors++;
        if ({b1.done0, b1.result} !== {1'b1, 8'h32}) begin
          miscompares++;
          $display("FAIL drop_result: got done0,result=%h want %h", {b1.done0, b1.result}, {1'b1, 8'h32});
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL drop_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_hold_past_done;
    logic exp_d0;
    @(negedge clk);
    b1.op0 = 3'd2; b1.a0 = 8'h81; b1.b0 = 8'h42; b1.req0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_d0 = (k == 2) || (k == 5);
      vectors++;
      if (b1.done0 !== exp_d0) begin
        miscompares++;
        $display("FAIL hold_done0 k=%0d: got %b want %b", k, b1.done0, exp_d0);
      end
      if (k == 2) begin
        vectors++;
        if (b1.result !== 8'hC3) begin
          miscompares++;
          $display("FAIL hold_result1: got %h want c3", b1.result);
        end
      end
      if (k == 3) begin
        b1.a0 = 8'h0F; b1.b0 = 8'h10;
      end
      if (k == 4) begin
        vectors++;
        if ({b1.busy, b1.alu_in1, b1.alu_in2} !== {1'b1, 8'h0F, 8'h10}) begin
          miscompares++;
          $display("FAIL hold_regrant: got %h want %h", {b1.busy, b1.alu_in1, b1.alu_in2}, {1'b1, 8'h0F, 8'h10});
        end
        b1.req0 = 1'b0;
      end
      if (k == 5) begin
        vectors++;
        if (b1.result !== 8'h1F) begin
          miscompares++;
          $display("FAIL hold_result2: got %h want 1f", b1.result);
        end
      end
      if (k == 6) begin
        vectors++;
        if (b1.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL hold_idle_busy: got %b want 0", b1.busy);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    b1.req0 = 1'b0; b1.op0 = '0; b1.a0 = '0; b1.b0 = '0;
    b1.req1 = 1'b0; b1.op1 = '0; b1.a1 = '0; b1.b1 = '0;
    b4.req0 = 1'b0; b4.op0 = '0; b4.a0 = '0; b4.b0 = '0;
    b4.req1 = 1'b0; b4.op1 = '0; b4.a1 = '0; b4.b1 = '0;
    test_reset();
    test_single_xor();
    test_tie_alternate();
    test_exec4();
    test_reset_mid_exec();
    test_drop_mid_exec();
    test_hold_past_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 8-bit ALU (the bitwise XOR/AND/OR/ADD unit) between two requesters: the instruction datapath (port 0) and a debug/self-test engine (port 1).
- Arbitrates round-robin, latches the winner's operands and drives the shared ALU for EXEC_CYCLES cycles.
- Captures the ALU output and returns it with a one-cycle done pulse to the winner.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

Parameters:
- WIDTH, 8: operand and result width.
- OPW, 3: ALU opcode width. The opcode is passed through unchanged.
- EXEC_CYCLES, 1: cycles the ALU inputs are held stable before capture. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  request from port 0; held until done0.
- op0  in  OPW  opcode, port 0.
- a0  in  WIDTH  operand 1, port 0.
- b0  in  WIDTH  operand 2, port 0.
- req1  in  1  request from port 1; held until done1.
- op1  in  OPW  opcode, port 1.
- a1  in  WIDTH  operand 1, port 1.
- b1  in  WIDTH  operand 2, port 1.
- done0  out  1  one-cycle pulse: result valid for port 0.
- done1  out  1  one-cycle pulse: result valid for port 1.
- result  out  WIDTH  registered ALU result; holds its value until the next capture.
- busy  out  1  high in EXEC and DONE.
- alu_op  out  OPW  opcode driven to the shared ALU.
- alu_in1  out  WIDTH  operand 1 to the ALU.
- alu_in2  out  WIDTH  operand 2 to the ALU.
- alu_out  in  WIDTH  combinational ALU output.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - done0, done1, busy, result, alu_op, alu_in1, alu_in2 all 0.
  - Exec counter 0. last_gnt=1, so port 0 wins the first tie.
- IDLE:
  - ALU outputs are driven to 0.
  - If only reqN is high, grant N. If both are high, grant the port that is not last_gnt.
  - On the granting edge: latch opN/aN/bN into internal registers, set last_gnt=N, load counter=EXEC_CYCLES-1, go to EXEC.
- EXEC:
  - alu_op/alu_in1/alu_in2 are driven from the latched registers and stay stable for the whole state.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: result<=alu_out, go to DONE.
- DONE:
  - doneN (granted port only) is high for exactly this cycle.
  - The ALU outputs keep the latched values.
  - Next state is IDLE.
- Latency: req sampled at edge E0 -> done high in cycle E0+EXEC_CYCLES+1 -> IDLE next cycle. With EXEC_CYCLES=1, done is high in the second cycle after grant.
- Handshake rules:
  - The requester deasserts req on the edge at which it samples done.
  - A req still high in the following IDLE cycle is a new request.
  - Operands from the requester are don't-care after the granting edge.
- Request dropped mid-EXEC: the operation completes, result is still captured and doneN still pulses.
- The losing port's request stays pending and is granted in the next IDLE cycle. Back-to-back alternation when both ports hold req:
  - EXEC_CYCLES=1: a grant every 3 cycles.
  - General case: a grant every EXEC_CYCLES+2 cycles.
- done0 and done1 are never high together. busy=0 only in IDLE.
- Reset mid-EXEC or mid-DONE: immediate return to the reset state with no done pulse. The in-flight operation is lost and the requester must re-request.
- Widths: result is exactly WIDTH bits of alu_out. No carry or flag handling; that stays in the ALU.

Test Plan:
- Single port-0 request, op=XOR, a0=8'hA5, b0=8'h3C, EXEC_CYCLES=1 -> alu_in1=8'hA5 and alu_in2=8'h3C in EXEC, done0 pulse in the second cycle after grant, result=8'h99, done1 never high.
- req0 and req1 asserted together out of reset (XOR 8'hFF^8'h0F and XOR 8'h55^8'h55) -> port 0 is served first with result 8'hF0, then port 1 with result 8'h00, and grants alternate 0,1,0,1 while both are held.
- EXEC_CYCLES=4, port-1 XOR 8'h12^8'h34 -> ALU inputs stable for 4 cycles, done1 in the fifth cycle after grant, result=8'h26.
- rst_n pulled low during EXEC of a port-0 request -> all outputs 0 asynchronously and no done0 pulse. After release, req0 still high is re-granted and completes normally.
- req0 dropped during EXEC and operands changed to 8'h00 -> the operation still completes on the latched operands and done0 pulses once with the correct result.
- Requester holds req0 one cycle past done0 -> a second grant and a second done0 occur, confirming the stated handshake rule.
